// File: rtl/spectrum_band_sequencer.sv
// Spectrum band sequencer: feeds mic samples through a shared band
// filter engine, keeps per-band peaks with frame decay for a bar display.
module spectrum_band_sequencer #(
  parameter int n_bands    = 12,
  parameter int w_mag      = 16,
  parameter int w_bar      = 9,
  parameter int decay_step = 64,
  parameter int timeout    = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic signed [10:0]         sample,
  input  logic                       frame_tick,
  output logic                       eng_start,
  output logic [$clog2(n_bands)-1:0] eng_band,
  output logic signed [10:0]         eng_sample,
  input  logic                       eng_done,
  input  logic [w_mag-1:0]           eng_mag,
  input  logic [$clog2(n_bands)-1:0] rd_band,
  output logic [w_bar-1:0]           rd_height,
  output logic                       busy,
  output logic                       overrun,
  output logic                       eng_timeout,
  input  logic                       clear
);

  localparam int bw = $clog2(n_bands);
  localparam int tw = $clog2(timeout + 1);
  localparam logic [bw-1:0] last_idx = bw'(n_bands - 1);
  localparam logic [tw-1:0] last_wait = tw'(timeout - 1);
  localparam logic [w_mag-1:0] step = w_mag'(decay_step);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    STORE,
    DECAY
  } state_t;

  state_t state, state_nx;

  logic [bw-1:0]     band;
  logic [tw-1:0]     wcnt;
  logic [w_mag-1:0]  mag_q;
  logic [w_mag-1:0]  peak [n_bands];
  logic              hold_full;
  logic signed [10:0] hold_data;
  logic              decay_pending;

  logic drain;
  logic to_hit;
  logic last_band;

  assign last_band = (band == last_idx);
  assign busy      = (state != IDLE);
  assign eng_start = (state == ISSUE);
  assign eng_band  = band;

  always_comb begin
    state_nx = state;
    drain    = 1'b0;
    to_hit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (decay_pending) begin
          state_nx = DECAY;
        end else if (hold_full) begin
          drain    = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (eng_done) begin
          state_nx = STORE;
        end else if (wcnt == last_wait) begin
          to_hit   = 1'b1;
          state_nx = STORE;
        end
      end
      STORE: state_nx = last_band ? IDLE : ISSUE;
      DECAY: state_nx = last_band ? IDLE : DECAY;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      band          <= '0;
      wcnt          <= '0;
      mag_q         <= '0;
      hold_full     <= 1'b0;
      hold_data     <= '0;
      decay_pending <= 1'b0;
      eng_sample    <= '0;
      rd_height     <= '0;
      overrun       <= 1'b0;
      eng_timeout   <= 1'b0;
      for (int i = 0; i < n_bands; i++) begin
        peak[i] <= '0;
      end
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          band <= '0;
          if (drain) begin
            eng_sample <= hold_data;
          end
        end
        ISSUE: wcnt <= '0;
        WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (eng_done) begin
            mag_q <= eng_mag;
          end else if (to_hit) begin
            mag_q <= '0;
          end
        end
        STORE: begin
          if (mag_q > peak[band]) begin
            peak[band] <= mag_q;
          end
          if (!last_band) begin
            band <= band + 1'b1;
          end
        end
        DECAY: begin
          if (peak[band] >= step) begin
            peak[band] <= peak[band] - step;
          end else begin
            peak[band] <= '0;
          end
          band <= last_band ? '0 : band + 1'b1;
        end
        default: ;
      endcase

      // a drain frees the slot in the same cycle, so a new strobe still fits
      if (sample_valid && (!hold_full || drain)) begin
        hold_data <= sample;
        hold_full <= 1'b1;
      end else if (drain) begin
        hold_full <= 1'b0;
      end

      overrun <= (overrun & ~clear)
               | (sample_valid & hold_full & ~drain);
      eng_timeout <= (eng_timeout & ~clear) | to_hit;
      decay_pending <= frame_tick
                     | (decay_pending & (state != IDLE));

      if (rd_band <= last_idx) begin
        rd_height <= peak[rd_band][w_mag-1 -: w_bar];
      end else begin
        rd_height <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_band_sequencer.sv
// Self-checking bench for spectrum_band_sequencer with an engine model
// and a per-band peak reference model.
module tb_spectrum_band_sequencer;

  logic               clk;
  logic               rst;
  logic               sample_valid;
  logic signed [10:0] sample;
  logic               frame_tick;
  logic               eng_start;
  logic [3:0]         eng_band;
  logic signed [10:0] eng_sample;
  logic               eng_done;
  logic [15:0]        eng_mag;
  logic [3:0]         rd_band;
  logic [8:0]         rd_height;
  logic               busy;
  logic               overrun;
  logic               eng_timeout;
  logic               clear;

  spectrum_band_sequencer dut (
    .clk(clk),
    .rst(rst),
    .sample_valid(sample_valid),
    .sample(sample),
    .frame_tick(frame_tick),
    .eng_start(eng_start),
    .eng_band(eng_band),
    .eng_sample(eng_sample),
    .eng_done(eng_done),
    .eng_mag(eng_mag),
    .rd_band(rd_band),
    .rd_height(rd_height),
    .busy(busy),
    .overrun(overrun),
    .eng_timeout(eng_timeout),
    .clear(clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int starts = 0;
  int cyc = 0;
  int band_log[$];
  logic [10:0] samp_log[$];
  int start_cyc[$];
  int eng_tab[16];
  bit eng_mute = 1'b0;
  int eng_lat = 5;
  int cnt = 0;
  int job_mag = 0;
  int pk[12];

  // engine model: answers eng_lat cycles after the start pulse
  initial begin
    eng_done = 1'b0;
    eng_mag = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      eng_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !eng_mute) begin
          eng_done = 1'b1;
          eng_mag = 16'(job_mag);
        end
      end
      if (eng_start) begin
        starts++;
        band_log.push_back(int'(eng_band));
        samp_log.push_back(eng_sample);
        start_cyc.push_back(cyc);
        job_mag = eng_tab[eng_band];
        cnt = eng_lat;
        if (eng_mute) eng_mag = 16'hFFFF;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sample(input logic [10:0] v);
    sample = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int q = 0;
    int n = 0;
    while (q < 3 && n < budget) begin
      tick();
      n++;
      if (!busy) q++;
      else q = 0;
    end
    chk("quiet_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic model_sweep();
    for (int b = 0; b < 12; b++) begin
      int v;
      v = eng_mute ? 0 : eng_tab[b];
      if (v > pk[b]) pk[b] = v;
    end
  endtask

  task automatic model_decay();
    for (int b = 0; b < 12; b++) begin
      pk[b] = (pk[b] >= 64) ? pk[b] - 64 : 0;
    end
  endtask

  task automatic read_all(input string tag);
    for (int b = 0; b < 16; b++) begin
      rd_band = 4'(b);
      tick();
      chk($sformatf("%s_rd%0d", tag, b), 32'(rd_height),
          (b < 12) ? 32'((pk[b] >> 7) & 511) : 32'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    for (int b = 0; b < 12; b++) pk[b] = 0;
  endtask

  initial begin
    int base;
    int nb;
    logic [10:0] s1, s2, s3;
    rst = 1'b0;
    sample_valid = 1'b0;
    sample = '0;
    frame_tick = 1'b0;
    rd_band = '0;
    clear = 1'b0;
    for (int b = 0; b < 16; b++) eng_tab[b] = 100 * (b + 1);
    for (int b = 0; b < 12; b++) pk[b] = 0;

    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(eng_timeout), 32'd0);
    chk("rst_start", 32'(eng_start), 32'd0);
    chk("rst_band", 32'(eng_band), 32'd0);
    chk("rst_sample", 32'(eng_sample), 32'd0);
    chk("rst_height", 32'(rd_height), 32'd0);
    rst = 1'b1;
    tick();

    // single sample, mag = 100*(band+1)
    base = starts;
    pulse_sample(11'd123);
    wait_quiet(500);
    model_sweep();
    chk("sweep_starts", 32'(starts - base), 32'd12);
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (band_log[base + i] == i && samp_log[base + i] == 11'd123) nb++;
    end
    chk("sweep_band_order", 32'(nb), 32'd12);
    rd_band = 4'd3;
    tick();
    chk("rd_band3", 32'(rd_height), 32'd3);
    read_all("basic");

    // random engine answers, latencies and samples
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 16; b++) eng_tab[b] = int'($urandom_range(0, 65535));
      eng_lat = int'($urandom_range(1, 8));
      s1 = 11'($urandom);
      base = starts;
      pulse_sample(s1);
      wait_quiet(500);
      model_sweep();
      chk("rand_starts", 32'(starts - base), 32'd12);
      chk("rand_sample", 32'(samp_log[base + 11]), 32'(s1));
      read_all($sformatf("rand%0d", r));
    end

    // three back-to-back strobes; third dropped, with concurrent clear
    eng_lat = 5;
    s1 = 11'h155;
    s2 = 11'h2AA;
    s3 = 11'h7FF;
    base = starts;
    sample_valid = 1'b1;
    sample = s1;
    tick();
    sample = s2;
    tick();
    chk("ovr_second_kept", 32'(overrun), 32'd0);
    sample = s3;
    clear = 1'b1;
    tick();
    sample_valid = 1'b0;
    clear = 1'b0;
    chk("ovr_set_vs_clear", 32'(overrun), 32'd1);
    wait_quiet(1000);
    model_sweep();
    chk("ovr_starts", 32'(starts - base), 32'd24);
    chk("ovr_first", 32'(samp_log[base]), 32'(s1));
    chk("ovr_second", 32'(samp_log[base + 23]), 32'(s2));
    chk("ovr_sticky", 32'(overrun), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    read_all("ovr");

    // decay: peaks 1000 (band 2 at 30), one frame_tick
    do_reset();
    for (int b = 0; b < 16; b++) eng_tab[b] = 1000;
    eng_tab[2] = 30;
    pulse_sample(11'd7);
    wait_quiet(500);
    model_sweep();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy) nb++;
    end
    model_decay();
    chk("decay_busy_cycles", 32'(nb), 32'd12);
    chk("decay_936", 32'(pk[0]), 32'd936);
    read_all("decay");

    // frame_tick with sample_valid in IDLE: decay first, then sweep
    for (int b = 0; b < 16; b++) eng_tab[b] = int'($urandom_range(0, 65535));
    base = starts;
    frame_tick = 1'b1;
    sample_valid = 1'b1;
    sample = 11'h0F0;
    tick();
    frame_tick = 1'b0;
    sample_valid = 1'b0;
    repeat (12) tick();
    chk("tick_then_sample_nostart", 32'(starts - base), 32'd0);
    wait_quiet(500);
    model_decay();
    model_sweep();
    chk("tick_then_sample_starts", 32'(starts - base), 32'd12);
    chk("tick_then_sample_ovr", 32'(overrun), 32'd0);
    read_all("tksv");

    // engine never answers
    eng_mute = 1'b1;
    base = starts;
    pulse_sample(11'h321);
    wait_quiet(5000);
    model_sweep();
    chk("to_flag", 32'(eng_timeout), 32'd1);
    chk("to_starts", 32'(starts - base), 32'd12);
    chk("to_last_band", 32'(band_log[base + 11]), 32'd11);
    chk("to_spacing", 32'(start_cyc[base + 1] - start_cyc[base]), 32'd257);
    read_all("to");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("to_cleared", 32'(eng_timeout), 32'd0);
    eng_mute = 1'b0;

    // reset while waiting on band 5; late eng_done ignored
    eng_lat = 5;
    for (int b = 0; b < 16; b++) eng_tab[b] = 100 * (b + 1);
    base = starts;
    pulse_sample(11'd55);
    nb = 0;
    while (starts < base + 6 && nb < 300) begin
      tick();
      nb++;
    end
    chk("mid_reach_band5", 32'(nb < 300), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int b = 0; b < 12; b++) pk[b] = 0;
    repeat (20) tick();
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_starts", 32'(starts - base), 32'd6);
    chk("mid_band", 32'(eng_band), 32'd0);
    read_all("mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
